sparce_sasa_writer: RTL and testbench

- Programming front-end for the SparCE SASA table: the writer side of the table's sasa_addr/sasa_data/sasa_wen port.
- Accepts a stream of 32-bit words (typically from a CSR/DMA path) and packs them into per-entry write transactions.
- Each SASA entry is two words, a preceding-PC word then a config word; the block emits one sasa_wen write per word.

---
 rtl/sparce_sasa_writer_if.sv | 20 ++
 rtl/sparce_sasa_writer.sv | 118 +++++++++++
 tb/tb_sparce_sasa_writer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sparce_sasa_writer_if.sv
// Stream-in and SASA table write port of the SparCE SASA writer.
// master: the writer (consumes the stream, drives the table); slave: the surrounding logic.
interface sparce_sasa_writer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        sasa_wen;

  modport master (
    input  in_data, in_valid,
    output in_ready, sasa_addr, sasa_data, sasa_wen
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, sasa_addr, sasa_data, sasa_wen
  );
endinterface

// File: rtl/sparce_sasa_writer.sv
// Packs a 32-bit word stream into SASA table writes (PC word, then CFG word, per entry).
// Optional word validation is enabled by defining SPARCE_SASA_CHECK_EN.
module sparce_sasa_writer #(
  parameter int unsigned SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_BASE    = 32'h0000_1000,
  parameter int unsigned IDXW         = $clog2(SASA_ENTRIES)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [IDXW:0]         num_entries,
  input  logic                  abort,
  sparce_sasa_writer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, PC, CFG} state_t;

  localparam logic [IDXW:0] MAX_N = (IDXW+1)'(SASA_ENTRIES);

  state_t          state, state_n;
  logic [IDXW-1:0] idx, idx_n, last, last_n;
  logic [31:0]     addr_q, addr_n, data_q, data_n;
  logic            wen_q, wen_n, done_q, done_n, err_q, err_n;
  logic            hs, bad;

  assign busy         = (state != IDLE);
  assign bus.in_ready = busy && !abort;
  assign hs           = bus.in_valid && bus.in_ready;

  assign bus.sasa_addr = addr_q;
  assign bus.sasa_data = data_q;
  assign bus.sasa_wen  = wen_q;
  assign done          = done_q;
  assign error         = err_q;

`ifdef SPARCE_SASA_CHECK_EN
  // PC words must be word aligned; CFG condition is OR/AND only, reserved bits zero
  assign bad = (state == PC) ? (bus.in_data[1:0] != 2'b00)
                             : (bus.in_data[11] || (bus.in_data[15:12] != 4'h0));
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    addr_n  = addr_q;
    data_n  = data_q;
    wen_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_entries == '0) begin
            done_n = 1'b1;
          end else if (num_entries > MAX_N) begin
            err_n = 1'b1;
          end else begin
            state_n = PC;
            idx_n   = '0;
            last_n  = IDXW'(num_entries - 1'b1);
          end
        end
      end
      default: begin
        if (abort) begin
          state_n = IDLE;
        end else if (hs) begin
          if (bad) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            wen_n  = 1'b1;
            data_n = bus.in_data;
            addr_n = SASA_BASE + 32'({idx, (state == CFG), 2'b00});
            if (state == PC) begin
              state_n = CFG;
            end else if (idx == last) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx + IDXW'(1);
              state_n = PC;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      idx    <= '0;
      last   <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      last   <= last_n;
      addr_q <= addr_n;
      data_q <= data_n;
      wen_q  <= wen_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

endmodule

// File: tb/tb_sparce_sasa_writer.sv
// Directed, table-driven bench for sparce_sasa_writer (SASA_ENTRIES=16, SASA_BASE=0x1000).
module tb_sparce_sasa_writer;

  typedef struct {
    logic        start;
    logic [4:0]  num;
    logic        abort;
    logic        valid;
    logic [31:0] data;
    logic        e_ready;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0;
  logic [4:0] num_entries = '0;
  logic       abort = 1'b0;
  logic       busy, done, error;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  sparce_sasa_writer_if bus ();

  sparce_sasa_writer #(
    .SASA_ENTRIES (16),
    .SASA_BASE    (32'h0000_1000)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .num_entries (num_entries),
    .abort       (abort),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 CLK = ~CLK;

  function automatic logic [68:0] outs();
    return {bus.in_ready, bus.sasa_wen, bus.sasa_addr, bus.sasa_data, busy, done, error};
  endfunction

  task automatic check(input string name, input logic [68:0] want);
    logic [68:0] got;
    got = outs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got ready=%b wen=%b addr=%h data=%h busy=%b done=%b err=%b want ready=%b wen=%b addr=%h data=%h busy=%b done=%b err=%b",
               name, got[68], got[67], got[66:35], got[34:3], got[2], got[1], got[0],
               want[68], want[67], want[66:35], want[34:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic add(input logic st, input logic [4:0] n, input logic ab, input logic v,
                     input logic [31:0] d, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic b, input logic dn, input logic er);
    vec_t x;
    x.start = st; x.num = n; x.abort = ab; x.valid = v; x.data = d;
    x.e_ready = r; x.e_wen = w; x.e_addr = a; x.e_data = wd;
    x.e_busy = b; x.e_done = dn; x.e_err = er;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic st, input logic [4:0] n, input logic ab,
                       input logic v, input logic [31:0] d);
    start = st; num_entries = n; abort = ab; bus.in_valid = v; bus.in_data = d;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Full load: back-to-back, then with gaps
    add(1, 2, 0, 0, 32'h0,         0, 0, 32'h0,    32'h0,         0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0100, 1, 0, 32'h0,    32'h0,         1, 0, 0);
    add(0, 0, 0, 1, 32'h0003_0041, 1, 1, 32'h1000, 32'h0000_0100, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0200, 1, 1, 32'h1004, 32'h0003_0041, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0005_0422, 1, 1, 32'h1008, 32'h0000_0200, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'h100C, 32'h0005_0422, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    add(1, 2, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0100, 1, 0, 32'h100C, 32'h0005_0422, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,         1, 1, 32'h1000, 32'h0000_0100, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0003_0041, 1, 0, 32'h1000, 32'h0000_0100, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,         1, 1, 32'h1004, 32'h0003_0041, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0200, 1, 0, 32'h1004, 32'h0003_0041, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,         1, 1, 32'h1008, 32'h0000_0200, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0005_0422, 1, 0, 32'h1008, 32'h0000_0200, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'h100C, 32'h0005_0422, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    // num_entries 0 and 17
    add(1, 0, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 1, 0);
    add(1, 17, 0, 0, 32'h0,        0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    add(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h100C, 32'h0005_0422, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    // Abort after the third handshake, then restart (start beats abort in IDLE)
    add(1, 3, 0, 0, 32'h0,         0, 0, 32'h100C, 32'h0005_0422, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0100, 1, 0, 32'h100C, 32'h0005_0422, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0003_0041, 1, 1, 32'h1000, 32'h0000_0100, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0200, 1, 1, 32'h1004, 32'h0003_0041, 1, 0, 0);
    add(0, 0, 1, 1, 32'h0005_0422, 0, 1, 32'h1008, 32'h0000_0200, 1, 0, 0);
    add(0, 0, 1, 1, 32'h0005_0422, 0, 0, 32'h1008, 32'h0000_0200, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,         0, 0, 32'h1008, 32'h0000_0200, 0, 0, 0);
    // start while busy is ignored; CFG word with condition 2'b10
    add(1, 5, 0, 1, 32'h0000_0300, 1, 0, 32'h1008, 32'h0000_0200, 1, 0, 0);
    add(0, 0, 0, 1, 32'h0003_0841, 1, 1, 32'h1000, 32'h0000_0300, 1, 0, 0);
`ifdef SPARCE_SASA_CHECK_EN
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h1000, 32'h0000_0300, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h1000, 32'h0000_0300, 0, 0, 0);
`else
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'h1004, 32'h0003_0841, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h1004, 32'h0003_0841, 0, 0, 0);
`endif

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), $urandom);
      #1 check($sformatf("reset%0d", i), '0);
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    nRST = 1'b1;
    #1 check("post_reset", '0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].start, vecs[i].num, vecs[i].abort, vecs[i].valid, vecs[i].data);
      #1 check($sformatf("vec%0d", i),
               {vecs[i].e_ready, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err});
    end

    // Asynchronous reset in the middle of a sequence drops the pending write
    @(negedge CLK);
    drive(1, 1, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 1, 32'h0000_0700);
    #1 check("mid_pc", {1'b1, 1'b0, vecs[$].e_addr, vecs[$].e_data, 1'b1, 1'b0, 1'b0});
    @(negedge CLK);
    drive(0, 0, 0, 1, 32'h0001_0001);
    #1 check("mid_cfg", {1'b1, 1'b1, 32'h1000, 32'h0000_0700, 1'b1, 1'b0, 1'b0});
    #1 nRST = 1'b0;
    #1 check("async_clear", '0);
    @(negedge CLK);
    nRST = 1'b1;
    #1 check("after_mid_reset", '0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    #1 check("no_lost_write", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
